// File: rtl/bless_ni_pkg.sv
// Shared definitions for the BLESS network interface.
// Flit field layout and port widths used by the NI and its FIFOs.
// Link convention: an all-zero word is idle, any nonzero word is a flit.
package bless_ni_pkg;

  // Flit field widths, LSB first: payload, Ydst, Xdst, Time, FlitId, PktId
  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned YDST_W    = 3;
  localparam int unsigned XDST_W    = 3;
  localparam int unsigned TIME_W    = 8;
  localparam int unsigned FLIT_ID_W = 4;
  localparam int unsigned PKT_ID_W  = 8;

  // Flit as seen on the NI <-> core / NI <-> router local port
  localparam int unsigned WIDTH_PORT_NI =
    PAYLOAD_W + YDST_W + XDST_W + TIME_W + FLIT_ID_W + PKT_ID_W;

  // Router-to-router links carry extra routing state beyond the NI flit
  localparam int unsigned PORT_EXTRA_W = 2;
  localparam int unsigned WIDTH_PORT   = WIDTH_PORT_NI + PORT_EXTRA_W;

  // Statistics counter widths
  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned FLIT_CNT_W = 16;

  // Field positions of an NI flit
  typedef struct packed {
    logic [PKT_ID_W-1:0]  pkt_id;
    logic [FLIT_ID_W-1:0] flit_id;
    logic [TIME_W-1:0]    tstamp;
    logic [XDST_W-1:0]    xdst;
    logic [YDST_W-1:0]    ydst;
    logic [PAYLOAD_W-1:0] payload;
  } ni_flit_t;

  // A word carries a flit iff it is nonzero
  function automatic logic flit_valid(input logic [WIDTH_PORT_NI-1:0] word);
    return |word;
  endfunction

endpackage

// File: rtl/bless_ni_fifo.sv
// ni_fifo: synchronous FIFO with async active-low reset of pointers/occupancy.
// Ports: clk, reset (async, active-low), push/din write side, pop/head read
// side (head is show-ahead), full/empty status.
// A push while full is accepted only when a pop happens on the same edge.
module ni_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Status from occupancy
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is not reset; empty flag masks stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bless_ni.sv
// bless_ni: network interface between a core and a bufferless (BLESS) router.
// Injection: core flits queue in a FIFO and are driven onto the router local
// input only in cycles where some neighbour link is idle (a free slot).
// Ejection: flits from the router local output queue for the core; flits that
// find the queue full are dropped and counted.
// Ports: clk, reset (async, active-low); inj_valid/inj_data/inj_ready core
// injection handshake; link_w/e/s/n snooped neighbour links; to_router /
// from_router router local port; ej_valid/ej_data/ej_ready core ejection
// handshake; ej_overflow sticky drop flag; drop_cnt, inj_cnt, ej_cnt stats.
module bless_ni
  import bless_ni_pkg::*;
#(
  parameter int unsigned INJ_DEPTH = 4,
  parameter int unsigned EJ_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inj_valid,
  input  logic [WIDTH_PORT_NI-1:0] inj_data,
  output logic                     inj_ready,
  input  logic [WIDTH_PORT-1:0]    link_w,
  input  logic [WIDTH_PORT-1:0]    link_e,
  input  logic [WIDTH_PORT-1:0]    link_s,
  input  logic [WIDTH_PORT-1:0]    link_n,
  output logic [WIDTH_PORT_NI-1:0] to_router,
  input  logic [WIDTH_PORT_NI-1:0] from_router,
  output logic                     ej_valid,
  output logic [WIDTH_PORT_NI-1:0] ej_data,
  input  logic                     ej_ready,
  output logic                     ej_overflow,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic [FLIT_CNT_W-1:0]    inj_cnt,
  output logic [FLIT_CNT_W-1:0]    ej_cnt
);

  logic                     inj_full;
  logic                     inj_empty;
  logic [WIDTH_PORT_NI-1:0] inj_head;
  logic                     inj_push;
  logic                     inj_pop;
  logic                     slot_free;

  logic                     ej_full;
  logic                     ej_empty;
  logic                     ej_in;
  logic                     ej_pop;
  logic                     ej_push;
  logic                     ej_drop;

  // Injection side: zero words complete the handshake but are never queued
  assign inj_ready = ~inj_full;
  assign inj_push  = inj_valid & ~inj_full & flit_valid(inj_data);

  // A slot is free when at least one neighbour link is idle this cycle
  assign slot_free = ~(|link_w) | ~(|link_e) | ~(|link_s) | ~(|link_n);

  assign to_router = (~inj_empty & slot_free) ? inj_head : '0;
  assign inj_pop   = flit_valid(to_router);

  ni_fifo #(
    .WIDTH (WIDTH_PORT_NI),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inj_push),
    .din   (inj_data),
    .pop   (inj_pop),
    .head  (inj_head),
    .full  (inj_full),
    .empty (inj_empty)
  );

  // Ejection side: a full queue still takes a flit if the core pops it
  assign ej_valid = ~ej_empty;
  assign ej_in    = flit_valid(from_router);
  assign ej_pop   = ej_valid & ej_ready;
  assign ej_push  = ej_in & (~ej_full | ej_pop);
  assign ej_drop  = ej_in & ej_full & ~ej_pop;

  ni_fifo #(
    .WIDTH (WIDTH_PORT_NI),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ej_push),
    .din   (from_router),
    .pop   (ej_pop),
    .head  (ej_data),
    .full  (ej_full),
    .empty (ej_empty)
  );

  // Statistics and sticky overflow; ej_cnt counts every arrival, dropped or not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_cnt     <= '0;
      ej_cnt      <= '0;
      drop_cnt    <= '0;
      ej_overflow <= 1'b0;
    end else begin
      if (inj_pop) inj_cnt <= inj_cnt + FLIT_CNT_W'(1);
      if (ej_in)   ej_cnt  <= ej_cnt + FLIT_CNT_W'(1);
      if (ej_drop) begin
        ej_overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/bless_ni.md
BLESS_NI -- requirements
Module: bless_ni

Interface
REQ-001 SHALL have parameter INJ_DEPTH, default 4, injection FIFO depth in flits (power of 2, >=2).
REQ-002 SHALL have parameter EJ_DEPTH, default 4, ejection FIFO depth in flits (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inj_valid  input  1  core offers a flit.
REQ-006 SHALL have port inj_data  input  `WIDTH_PORT_NI  core flit [PktId, FlitId, Time, Xdst, Ydst, payload].
REQ-007 SHALL have port inj_ready  output  1  injection FIFO can accept.
REQ-008 SHALL have port link_w, link_e, link_s, link_n  input  `WIDTH_PORT each  router neighbour inputs (snoop only).
REQ-009 SHALL have port to_router  output  `WIDTH_PORT_NI  drives router dinLocal.
REQ-010 SHALL have port from_router  input  `WIDTH_PORT_NI  router doutLocal.
REQ-011 SHALL have port ej_valid  output  1  ejected flit available to core.
REQ-012 SHALL have port ej_data  output  `WIDTH_PORT_NI  head ejected flit.
REQ-013 SHALL have port ej_ready  input  1  core accepts ejected flit.
REQ-014 SHALL have port ej_overflow  output  1  sticky: ejected flit dropped.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of dropped ejected flits.
REQ-016 SHALL have ports inj_cnt, ej_cnt  output  16 each  wrapping counts of flits sent to / received from router.

Function
REQ-017 Flit validity SHALL follow link convention: all-zero word = idle, any nonzero = valid flit.
REQ-018 inj_ready SHALL be 1 iff injection FIFO not full; push on inj_valid & inj_ready & inj_data!=0.
REQ-019 inj_valid & inj_ready with inj_data==0 SHALL be accepted (handshake completes) and discarded, no push.
REQ-020 Slot-free condition SHALL be: at least one of link_w/e/s/n equals zero in the current cycle.
REQ-021 to_router SHALL be combinational: FIFO head when FIFO non-empty and slot-free, else zero.
REQ-022 Head SHALL pop at the clock edge where to_router is nonzero; inj_cnt increments same edge.
REQ-023 Injection of a pushed flit SHALL take at minimum 1 cycle (push edge, then present next cycle); no bypass.
REQ-024 Simultaneous push and pop on injection FIFO SHALL both occur; full FIFO rejects push regardless of pop.
REQ-025 from_router!=0 at a clock edge SHALL push into ejection FIFO if not full, ej_cnt increments.
REQ-026 Ejection FIFO full with concurrent ej_valid & ej_ready pop SHALL accept the push (no drop).
REQ-027 Ejection FIFO full without pop SHALL drop the flit, set ej_overflow, increment drop_cnt saturating at 255; ej_cnt still increments.
REQ-028 ej_valid SHALL be 1 iff ejection FIFO non-empty; ej_data = head, stable while ej_valid & ~ej_ready.
REQ-029 FIFO pointers SHALL wrap modulo depth; occupancy counter width log2(depth)+1.
REQ-030 FIFOs SHALL preserve order; no flit duplication or reordering.

Reset
REQ-031 On reset low, both FIFOs SHALL empty immediately (async); inj_ready=1, ej_valid=0, to_router=0.
REQ-032 On reset, ej_overflow=0, drop_cnt=0, inj_cnt=0, ej_cnt=0; ej_data don't-care while ej_valid=0.
REQ-033 Reset mid-operation SHALL discard all buffered flits; no flit emitted on to_router until a new push.
REQ-034 ej_overflow SHALL clear only by reset.

Structure
REQ-035 `WIDTH_PORT, `WIDTH_PORT_NI and flit field positions SHALL come from global.v; no local redefinition.
REQ-036 A single sub-module ni_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head) SHALL be instantiated twice.
REQ-037 Slot-free logic, counters and overflow logic SHALL reside in bless_ni.

Verification
REQ-038 Push flits 0x11,0x22 with all links zero -> to_router shows 0x11 then 0x22 on consecutive cycles, inj_cnt=2.
REQ-039 All four links nonzero for 5 cycles with 1 flit queued -> to_router=0 throughout; first cycle one link zero -> flit emitted, popped.
REQ-040 Push 4 flits while links busy -> inj_ready=0 after 4th; 5th inj_valid stalls; unblock -> order preserved.
REQ-041 ej_ready=0, 6 nonzero from_router flits -> 4 buffered, drop_cnt=2, ej_overflow=1, ej_cnt=6.
REQ-042 FIFO full, from_router valid with ej_ready=1 same cycle -> no drop, occupancy stays 4.
REQ-043 Assert reset with both FIFOs half full -> ej_valid=0, to_router=0, counters 0 immediately, no stale flits after release.
